// File: rtl/lock_supervisor_pkg.sv
// Lock supervisor shared types.
// FSM state encoding and timer sizing helper.
package lock_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_PWRDN    = 3'd0,
    ST_RESET    = 3'd1,
    ST_WAIT     = 3'd2,
    ST_DEBOUNCE = 3'd3,
    ST_LOCKED   = 3'd4
  } lsup_state_e;

  // Width able to hold the largest of the three cycle limits.
  function automatic int unsigned tmr_width(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lock_supervisor_channel.sv
// One supervised MMCM/PLL channel.
// Synchronizer, reset/lock FSM, shared timer, loss counter.
module lock_supervisor_channel
  import lock_supervisor_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 1000,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH     = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 locked_i,
  input  logic                 pwrdn_i,
  input  logic                 clear_i,
  output logic                 pll_rst_o,
  output logic                 pll_pwrdn_o,
  output logic                 locked_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  localparam int unsigned TW =
    tmr_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK sample that triggers DEBOUNCE is the first
  // of the stable run, so DEBOUNCE itself covers the rest.
  localparam logic [TW-1:0] STB_LAST =
    TW'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]           sync_q;
  logic                 lock_s;
  lsup_state_e          state_q, state_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 tmo_q;
  logic                 loss_evt;
  logic                 tmo_evt;

  // Two-flop synchronizer for the asynchronous LOCKED input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[0], locked_i};
  end

  assign lock_s = sync_q[1];

  // Next-state, timer and event decode; power-down overrides all.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    loss_evt = 1'b0;
    tmo_evt  = 1'b0;
    if (pwrdn_i) begin
      state_d = ST_PWRDN;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        ST_PWRDN: begin
          state_d = ST_RESET;
          tmr_d   = '0;
        end
        ST_RESET: begin
          if (tmr_q == RST_LAST) begin
            state_d = ST_WAIT;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_ONE;
          end
        end
        ST_WAIT: begin
          if (lock_s) begin
            state_d = (STABLE_CYCLES == 1) ? ST_LOCKED : ST_DEBOUNCE;
            tmr_d   = '0;
          end else if (tmr_q == TO_LAST) begin
            state_d = ST_RESET;
            tmr_d   = '0;
            tmo_evt = 1'b1;
          end else begin
            tmr_d = tmr_q + TMR_ONE;
          end
        end
        ST_DEBOUNCE: begin
          if (!lock_s) begin
            state_d = ST_WAIT;
            tmr_d   = '0;
          end else if (tmr_q == STB_LAST) begin
            state_d = ST_LOCKED;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_ONE;
          end
        end
        ST_LOCKED: begin
          if (!lock_s) begin
            state_d  = ST_RESET;
            tmr_d    = '0;
            loss_evt = 1'b1;
          end
        end
        default: begin
          state_d = ST_RESET;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // FSM state and timer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RESET;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Saturating loss counter and sticky timeout; events beat clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      if (clear_i) begin
        cnt_q <= loss_evt ? CNT_ONE : '0;
      end else if (loss_evt && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
      tmo_q <= clear_i ? tmo_evt : (tmo_q | tmo_evt);
    end
  end

  assign pll_rst_o   = (state_q == ST_RESET) || (state_q == ST_PWRDN);
  assign pll_pwrdn_o = (state_q == ST_PWRDN);
  assign locked_o    = (state_q == ST_LOCKED);
  assign timeout_o   = tmo_q;
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/lock_supervisor.sv
// Multi-channel MMCM/PLL lock supervisor.
// Replicates the channel block and registers the all-locked AND.
module lock_supervisor
  import lock_supervisor_pkg::*;
#(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 1000,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH     = 6
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [CHANNELS-1:0]           I_LOCKED,
  input  logic [CHANNELS-1:0]           I_PWRDWN,
  input  logic                          I_CLEAR,
  output logic [CHANNELS-1:0]           O_PLL_RST,
  output logic [CHANNELS-1:0]           O_PLL_PWRDWN,
  output logic [CHANNELS-1:0]           O_LOCKED,
  output logic                          O_ALL_LOCKED,
  output logic [CHANNELS-1:0]           O_TIMEOUT,
  output logic [CHANNELS*CNT_WIDTH-1:0] O_CNT
);

  logic all_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    lock_supervisor_channel #(
      .RST_CYCLES    (RST_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_WIDTH     (CNT_WIDTH)
    ) u_ch (
      .clk_i       (CLK),
      .rst_i       (RST),
      .locked_i    (I_LOCKED[i]),
      .pwrdn_i     (I_PWRDWN[i]),
      .clear_i     (I_CLEAR),
      .pll_rst_o   (O_PLL_RST[i]),
      .pll_pwrdn_o (O_PLL_PWRDWN[i]),
      .locked_o    (O_LOCKED[i]),
      .timeout_o   (O_TIMEOUT[i]),
      .cnt_o       (O_CNT[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  // Registered AND of every channel's lock status.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) all_q <= 1'b0;
    else     all_q <= &O_LOCKED;
  end

  assign O_ALL_LOCKED = all_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// Directed bench for lock_supervisor.
// Two channels, LOCK_TIMEOUT=10, CNT_WIDTH=2, other defaults.
module tb_lock_supervisor;

  localparam int CH = 2;
  localparam int CW = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic [CH-1:0] I_LOCKED;
  logic [CH-1:0] I_PWRDWN;
  logic          I_CLEAR;
  logic [CH-1:0] O_PLL_RST;
  logic [CH-1:0] O_PLL_PWRDWN;
  logic [CH-1:0] O_LOCKED;
  logic          O_ALL_LOCKED;
  logic [CH-1:0] O_TIMEOUT;
  logic [CH*CW-1:0] O_CNT;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  lock_supervisor #(
    .CHANNELS      (CH),
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (10),
    .STABLE_CYCLES (16),
    .CNT_WIDTH     (CW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .I_LOCKED     (I_LOCKED),
    .I_PWRDWN     (I_PWRDWN),
    .I_CLEAR      (I_CLEAR),
    .O_PLL_RST    (O_PLL_RST),
    .O_PLL_PWRDWN (O_PLL_PWRDWN),
    .O_LOCKED     (O_LOCKED),
    .O_ALL_LOCKED (O_ALL_LOCKED),
    .O_TIMEOUT    (O_TIMEOUT),
    .O_CNT        (O_CNT)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // Count consecutive samples where O_PLL_RST[ch] equals val.
  task automatic run_len(input logic ch, input logic val,
                         output int n);
    n = 0;
    while (O_PLL_RST[ch] === val && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_lock(input logic ch, input string tag);
    int w = 0;
    while (O_LOCKED[ch] !== 1'b1 && w < 100) begin
      w++;
      tick();
    end
    chk(tag, 32'(O_LOCKED[ch]), 32'd1);
  endtask

  initial begin
    int n;
    RST = 1'b1;
    I_LOCKED = '0;
    I_PWRDWN = '0;
    I_CLEAR = 1'b0;
    tick();
    tick();
    chk("rst_pllrst", 32'(O_PLL_RST), 32'h3);
    chk("rst_pwrdn", 32'(O_PLL_PWRDWN), 32'h0);
    chk("rst_locked", 32'(O_LOCKED), 32'h0);
    chk("rst_all", 32'(O_ALL_LOCKED), 32'h0);
    chk("rst_tmo", 32'(O_TIMEOUT), 32'h0);
    chk("rst_cnt", 32'(O_CNT), 32'h0);

    // Release; RESET lasts 4 cycles, then WAIT_LOCK.
    RST = 1'b0;
    run_len(1'b0, 1'b1, n);
    chk("rst_len", 32'(n), 32'd4);
    // Lock rises at WAIT_LOCK entry: locked 2+16 later.
    I_LOCKED = 2'b11;
    repeat (8) tick();
    // One-cycle glitch on channel 1 while debouncing.
    I_LOCKED = 2'b01;
    chk("dbn_lo", 32'(O_LOCKED), 32'h0);
    tick();
    I_LOCKED = 2'b11;
    repeat (8) tick();
    chk("pre_lock", 32'(O_LOCKED), 32'h0);
    tick();
    chk("lock0_t18", 32'(O_LOCKED), 32'h1);
    chk("all_lo", 32'(O_ALL_LOCKED), 32'h0);
    // Channel 1 relocks 18 cycles after the glitch ends.
    repeat (8) tick();
    chk("glitch_lk1", 32'(O_LOCKED), 32'h1);
    chk("glitch_cnt", 32'(O_CNT), 32'h0);
    tick();
    chk("lock1", 32'(O_LOCKED), 32'h3);
    chk("all_lag", 32'(O_ALL_LOCKED), 32'h0);
    tick();
    chk("all_lk", 32'(O_ALL_LOCKED), 32'h1);
    chk("no_tmo", 32'(O_TIMEOUT), 32'h0);

    // Five losses on channel 1; 2-bit counter stops at 3.
    for (int k = 1; k <= 5; k++) begin
      I_LOCKED[1] = 1'b0;
      tick();
      I_LOCKED[1] = 1'b1;
      tick();
      chk("loss_hold", 32'(O_LOCKED[1]), 32'd1);
      tick();
      chk("loss_drop", 32'(O_LOCKED[1]), 32'd0);
      wait_lock(1'b1, "relock1");
      chk("loss_cnt", 32'(O_CNT),
          32'(((k > 3) ? 3 : k) << 2));
    end

    // Clear in the same cycle as a loss: counter reads 1.
    I_LOCKED[1] = 1'b0;
    tick();
    I_LOCKED[1] = 1'b1;
    tick();
    I_CLEAR = 1'b1;
    tick();
    I_CLEAR = 1'b0;
    chk("clr_loss", 32'(O_CNT), 32'h4);
    wait_lock(1'b1, "relock2");

    // Power down locked channel 0: no loss counted.
    I_PWRDWN = 2'b01;
    tick();
    chk("pd_pwr", 32'(O_PLL_PWRDWN), 32'h1);
    chk("pd_lk", 32'(O_LOCKED), 32'h2);
    chk("pd_rst", 32'(O_PLL_RST), 32'h1);
    chk("pd_cnt", 32'(O_CNT), 32'h4);
    repeat (3) tick();
    I_PWRDWN = 2'b00;
    tick();
    run_len(1'b0, 1'b1, n);
    chk("pd_rel_rst", 32'(n), 32'd4);
    chk("pd_rel_pwr", 32'(O_PLL_PWRDWN), 32'h0);
    wait_lock(1'b0, "relock0");
    chk("pd_cnt2", 32'(O_CNT), 32'h4);

    // Channel 0 never locks: 4 reset + 10 wait, repeating.
    I_PWRDWN = 2'b01;
    I_LOCKED = 2'b10;
    repeat (3) tick();
    I_PWRDWN = 2'b00;
    tick();
    run_len(1'b0, 1'b1, n);
    chk("to_rst1", 32'(n), 32'd4);
    chk("to_flag0", 32'(O_TIMEOUT), 32'h0);
    run_len(1'b0, 1'b0, n);
    chk("to_wait1", 32'(n), 32'd10);
    chk("to_flag1", 32'(O_TIMEOUT), 32'h1);
    run_len(1'b0, 1'b1, n);
    chk("to_rst2", 32'(n), 32'd4);
    run_len(1'b0, 1'b0, n);
    chk("to_wait2", 32'(n), 32'd10);

    // Plain clear on a quiet cycle.
    I_CLEAR = 1'b1;
    tick();
    I_CLEAR = 1'b0;
    chk("clr_tmo", 32'(O_TIMEOUT), 32'h0);
    chk("clr_cnt", 32'(O_CNT), 32'h0);
    run_len(1'b0, 1'b1, n);
    chk("to_rst3", 32'(n), 32'd3);
    // Clear during the timeout cycle: the flag still sets.
    repeat (9) tick();
    chk("to_last_wait", 32'(O_PLL_RST), 32'h0);
    I_CLEAR = 1'b1;
    tick();
    I_CLEAR = 1'b0;
    chk("clr_vs_tmo", 32'(O_TIMEOUT), 32'h1);
    chk("to_rst4", 32'(O_PLL_RST), 32'h1);

    // Reset mid-operation aborts immediately.
    tick();
    RST = 1'b1;
    #1;
    chk("mid_rst", 32'(O_PLL_RST), 32'h3);
    chk("mid_lk", 32'(O_LOCKED), 32'h0);
    chk("mid_tmo", 32'(O_TIMEOUT), 32'h0);
    chk("mid_all", 32'(O_ALL_LOCKED), 32'h0);
    tick();
    RST = 1'b0;
    run_len(1'b1, 1'b1, n);
    chk("post_rst", 32'(n), 32'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
